chan_arbiter: RTL

CHAN_ARBITER -- requirements
Module: chan_arbiter

---
 rtl/chan_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/chan_arbiter.sv
// rtl/chan_arbiter.sv - packet-granular round-robin merge of three router channels
//
// Purpose: merges router channels 0..2 onto one byte stream. A channel is
// granted for a whole packet (header, header[7:2] payload bytes, parity),
// and grants rotate round-robin after the last granted channel.
//
// Ports:
//   clock                  sole clock, rising edge
//   reset                  synchronous, active-low
//   arb_en                 1 = grant new packets; 0 = finish current, then idle
//   data_0..2, data_vld_0..2   channel byte and byte-valid
//   suspend_0..2           read throttle to each channel (1 = do not read)
//   out_data, out_vld      merged byte, valid one clock after its transfer
//   out_suspend            downstream throttle (1 = no new transfer)
//   grant                  one-hot granted channel, 000 when idle
//   busy                   1 while a packet is being transferred

module chan_arbiter (
   input  logic       clock,
   input  logic       reset,
   input  logic       arb_en,
   input  logic [7:0] data_0,
   input  logic [7:0] data_1,
   input  logic [7:0] data_2,
   input  logic       data_vld_0,
   input  logic       data_vld_1,
   input  logic       data_vld_2,
   output logic       suspend_0,
   output logic       suspend_1,
   output logic       suspend_2,
   output logic [7:0] out_data,
   output logic       out_vld,
   input  logic       out_suspend,
   output logic [2:0] grant,
   output logic       busy
);

   typedef enum logic {IDLE, XFER} state_t;

   state_t     state, state_nxt;
   logic [2:0] grant_nxt;
   logic [1:0] last_grant, last_grant_nxt;
   logic [6:0] remaining, remaining_nxt;
   logic [7:0] out_data_nxt;
   logic       out_vld_nxt;

   logic [2:0] req;
   logic [1:0] pick;
   logic       pick_ok;
   logic [1:0] sel;
   logic [7:0] sel_data;
   logic       sel_vld;
   logic       xfer;

   assign req = {data_vld_2, data_vld_1, data_vld_0};

   // Round-robin: first requester after last_grant, in the order 0->1->2->0.
   always_comb begin
      pick_ok = |req;
      pick    = 2'd0;
      case (last_grant)
         2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
   end

   // Index and data of the currently granted channel.
   always_comb begin
      sel = 2'd0;
      case (grant)
         3'b010:  sel = 2'd1;
         3'b100:  sel = 2'd2;
         default: sel = 2'd0;
      endcase
   end

   always_comb begin
      sel_data = data_0;
      sel_vld  = data_vld_0;
      case (sel)
         2'd1: begin
            sel_data = data_1;
            sel_vld  = data_vld_1;
         end
         2'd2: begin
            sel_data = data_2;
            sel_vld  = data_vld_2;
         end
         default: begin
            sel_data = data_0;
            sel_vld  = data_vld_0;
         end
      endcase
   end

   assign xfer = (state == XFER) && sel_vld && !out_suspend;
   assign busy = (state == XFER);

   // Granted channel follows out_suspend; everyone else stays held off.
   assign suspend_0 = !((state == XFER) && grant[0] && !out_suspend);
   assign suspend_1 = !((state == XFER) && grant[1] && !out_suspend);
   assign suspend_2 = !((state == XFER) && grant[2] && !out_suspend);

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      remaining_nxt  = remaining;
      out_data_nxt   = out_data;
      out_vld_nxt    = 1'b0;
      case (state)
         IDLE: begin
            grant_nxt = 3'b000;
            if (arb_en && pick_ok) begin
               grant_nxt = 3'b001 << pick;
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (xfer) begin
               out_vld_nxt  = 1'b1;
               out_data_nxt = sel_data;
               // remaining==0 marks the header; it counts payload plus parity.
               if (remaining == 7'd0) begin
                  remaining_nxt = {1'b0, sel_data[7:2]} + 7'd1;
               end else begin
                  remaining_nxt = remaining - 7'd1;
                  if (remaining == 7'd1) begin
                     state_nxt      = IDLE;
                     grant_nxt      = 3'b000;
                     last_grant_nxt = sel;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 3'b000;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         grant      <= 3'b000;
         last_grant <= 2'd2;
         remaining  <= 7'd0;
         out_data   <= 8'h00;
         out_vld    <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         remaining  <= remaining_nxt;
         out_data   <= out_data_nxt;
         out_vld    <= out_vld_nxt;
      end
   end

endmodule
